// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random-word generator with a one-entry valid/ready output buffer.
// Optional drop counter output enabled by defining LFSR_RNG_DROP_CNT_EN.
module lfsr_rng #(
    parameter int              WIDTH  = 13,
    parameter logic [WIDTH-1:0] TAPS  = 13'h100D,
    parameter logic [WIDTH-1:0] SEED  = 13'h000F,
    parameter int              SHIFTS = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] rnd,
`ifdef LFSR_RNG_DROP_CNT_EN
    output logic [15:0]      drop_count,
`endif
    output logic [WIDTH-1:0] state
);

    localparam int             CW   = $clog2(SHIFTS + 1);
    localparam logic [CW-1:0] LAST = CW'(SHIFTS - 1);

    logic [CW-1:0]    count;
    logic             fb;
    logic [WIDTH-1:0] next_state;
    logic             lockup;
    logic             shift_en;
    logic             word_done;
    logic             accept;

    assign fb         = ^(state & TAPS);
    assign next_state = {state[WIDTH-2:0], fb};
    assign lockup     = (state == '0);
    assign shift_en   = enable && !seed_load && !lockup;
    assign word_done  = shift_en && (count == LAST);
    // A finished word is taken if the buffer is empty or being drained this edge.
    assign accept     = !out_valid || out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SEED;
            count <= '0;
        end else if (seed_load) begin
            state <= (seed_in == '0) ? SEED : seed_in;
            count <= '0;
        end else if (lockup) begin
            state <= SEED;
            count <= '0;
        end else if (enable) begin
            state <= next_state;
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rnd       <= '0;
            out_valid <= 1'b0;
        end else if (seed_load) begin
            out_valid <= 1'b0;
        end else if (word_done && accept) begin
            rnd       <= next_state;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LFSR_RNG_DROP_CNT_EN
    logic dropped;
    assign dropped = word_done && !accept;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (seed_load) begin
            drop_count <= '0;
        end else if (dropped && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: directed literal checks plus a randomized run
// compared every cycle against a shift-count based reference model.
module tb_lfsr_rng;

    localparam int          W    = 13;
    localparam logic [12:0] TAPS = 13'h100D;
    localparam logic [12:0] SEED = 13'h000F;
    localparam int          SH   = 13;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        seed_load = 1'b0;
    logic [12:0] seed_in = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [12:0] rnd;
    logic [12:0] state;
`ifdef LFSR_RNG_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    logic       e4 = 1'b0;
    logic       seed_load4 = 1'b0;
    logic [3:0] seed_in4 = '0;
    logic       out_ready4 = 1'b0;
    logic       out_valid4;
    logic [3:0] rnd4;
    logic [3:0] state4;
`ifdef LFSR_RNG_DROP_CNT_EN
    logic [15:0] drop_count4;
`endif

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    always #5 clock = ~clock;

    lfsr_rng #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED), .SHIFTS(SH)) dut (
        .clock(clock), .reset(reset), .enable(enable), .seed_load(seed_load),
        .seed_in(seed_in), .out_ready(out_ready), .out_valid(out_valid), .rnd(rnd),
`ifdef LFSR_RNG_DROP_CNT_EN
        .drop_count(drop_count),
`endif
        .state(state)
    );

    lfsr_rng #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h1), .SHIFTS(15)) dut4 (
        .clock(clock), .reset(reset), .enable(e4), .seed_load(seed_load4),
        .seed_in(seed_in4), .out_ready(out_ready4), .out_valid(out_valid4), .rnd(rnd4),
`ifdef LFSR_RNG_DROP_CNT_EN
        .drop_count(drop_count4),
`endif
        .state(state4)
    );

    // Reference: parity of tapped bits shifted in at the bottom.
    function automatic logic [12:0] lfsr_step(input logic [12:0] s);
        int unsigned v;
        int unsigned p;
        v = int'(s);
        p = $countones(v & int'(TAPS)) % 2;
        return 13'(((v << 1) | p) & 32'h1FFF);
    endfunction

    // Model tracks shifts taken since the last seed; every SH-th shift yields a word.
    logic [12:0] m_state;
    int          m_shifts;
    logic [12:0] m_rnd;
    logic        m_valid;
    int          m_drop;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state  <= SEED;
            m_shifts <= 0;
            m_rnd    <= '0;
            m_valid  <= 1'b0;
            m_drop   <= 0;
        end else if (seed_load) begin
            m_state  <= (seed_in == 0) ? SEED : seed_in;
            m_shifts <= 0;
            m_valid  <= 1'b0;
            m_drop   <= 0;
        end else begin
            if (m_state == 0) begin
                m_state  <= SEED;
                m_shifts <= 0;
            end else if (enable) begin
                m_state  <= lfsr_step(m_state);
                m_shifts <= (m_shifts + 1) % SH;
            end
            if (enable && m_state != 0 && (m_shifts + 1) % SH == 0) begin
                if (!m_valid || out_ready) begin
                    m_rnd   <= lfsr_step(m_state);
                    m_valid <= 1'b1;
                end else if (m_drop < 65535) begin
                    m_drop <= m_drop + 1;
                end
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            bit bad;
            bad = (state !== m_state) || (out_valid !== m_valid) || (rnd !== m_rnd);
`ifdef LFSR_RNG_DROP_CNT_EN
            bad = bad || (drop_count !== 16'(m_drop));
`endif
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL model t=%0t: state=%h/%h valid=%b/%b rnd=%h/%h (got/expected)",
                         $time, state, m_state, out_valid, m_valid, rnd, m_rnd);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] r1;
        int          pulses;
        int          n;
        #1 reset = 1'b1;
        repeat (2) tick();
        chk("reset state", 32'(state), 32'h000F);
        chk("reset valid", 32'(out_valid), 0);
        chk("reset rnd", 32'(rnd), 0);
`ifdef LFSR_RNG_DROP_CNT_EN
        chk("reset drop", 32'(drop_count), 0);
`endif
        reset = 1'b0;
        enable = 1'b1;
        check_en = 1'b1;

        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e == 1) chk("state edge1", 32'(state), 32'h001F);
            if (e == 2) chk("state edge2", 32'(state), 32'h003F);
            if (e == 3) chk("state edge3", 32'(state), 32'h007F);
            if (e == 9) chk("state edge9", 32'(state), 32'h1FFF);
            if (e == 12) chk("valid before latency", 32'(out_valid), 0);
            if (e == 13) begin
                chk("first valid", 32'(out_valid), 1);
                chk("first rnd", 32'(rnd), 32'h1FF4);
            end
        end

        repeat (13) tick();
        chk("held rnd", 32'(rnd), 32'h1FF4);
        chk("held valid", 32'(out_valid), 1);
`ifdef LFSR_RNG_DROP_CNT_EN
        chk("drop count one", 32'(drop_count), 1);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid falls after take", 32'(out_valid), 0);

        out_ready = 1'b1;
        pulses = 0;
        repeat (39) begin
            tick();
            if (out_valid) pulses++;
        end
        chk("pulses per 39 cycles", 32'(pulses), 3);

        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("word arrives", 32'(out_valid), 1);
        r1 = rnd;
        repeat (12) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("b2b valid stays", 32'(out_valid), 1);
        chk("b2b rnd updated", 32'(rnd != r1), 1);

        repeat (7) tick();
        seed_load = 1'b1;
        seed_in = '0;
        tick();
        seed_load = 1'b0;
        chk("zero seed fallback", 32'(state), 32'h000F);
        chk("seed clears valid", 32'(out_valid), 0);
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e == 12) chk("reseed latency", 32'(out_valid), 0);
            if (e == 13) begin
                chk("reseed valid", 32'(out_valid), 1);
                chk("reseed rnd", 32'(rnd), 32'h1FF4);
            end
        end

        seed_load = 1'b1;
        seed_in = 13'h1ABC;
        tick();
        seed_load = 1'b0;
        enable = 1'b0;
        chk("seed no shift", 32'(state), 32'h1ABC);
        repeat (5) begin
            tick();
            chk("frozen state", 32'(state), 32'h1ABC);
        end
        enable = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e == 12) chk("frozen count latency", 32'(out_valid), 0);
            if (e == 13) chk("frozen count word", 32'(out_valid), 1);
        end

        repeat (4) tick();
        #2 reset = 1'b1;
        #1;
        chk("async rst rnd", 32'(rnd), 0);
        chk("async rst valid", 32'(out_valid), 0);
        chk("async rst state", 32'(state), 32'h000F);
        tick();
        reset = 1'b0;

        e4 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("w4 period", 32'((state4 != 0) && ((k == 15) == (state4 == 4'h1))), 1);
        end
        e4 = 1'b0;
        chk("w4 word valid", 32'(out_valid4), 1);
        chk("w4 word rnd", 32'(rnd4), 1);
`ifdef LFSR_RNG_DROP_CNT_EN
        chk("w4 drop", 32'(drop_count4), 0);
`endif

        for (int c = 0; c < 900; c++) begin
            tick();
            enable    = ($urandom_range(0, 9) < 8);
            out_ready = (c < 450) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            seed_load = ($urandom_range(0, 59) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 13'h0 : 13'($urandom);
        end
        tick();
        seed_load = 1'b0;
        enable = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
- Parametrised Fibonacci LFSR random-word generator.
- Produces one fresh WIDTH-bit word every SHIFTS enabled shifts.
- Each word is offered through a one-entry valid/ready output buffer.
- Supports runtime seeding, all-zero lockup recovery and word-drop on back-pressure.
- Feeds game/logic blocks that need random values on demand.

Parameters:
WIDTH, 13, LFSR and output word width (>=2)
TAPS, 13'h100D, feedback tap mask, WIDTH bits; bit i set = state[i] enters feedback XOR (default taps 12,3,2,0)
SEED, 13'h000F, reset/fallback state, WIDTH bits, must be nonzero
SHIFTS, 13, shifts per output word (1..2^16-1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high; reset reset, clock clock
enable  in  1  LFSR advances one shift per clock while high
seed_load  in  1  one-cycle pulse: load seed_in into LFSR
seed_in  in  WIDTH  seed value sampled when seed_load=1
out_ready  in  1  consumer accepts rnd this cycle
out_valid  out  1  rnd holds an unconsumed word
rnd  out  WIDTH  output word
state  out  WIDTH  live LFSR state, for debug

Behaviour:
- Reset (async) values:
  - state=SEED, shift counter=0.
  - rnd=0, out_valid=0.
  - drop_count=0 when the optional feature is enabled.
- Feedback: fb = XOR-reduce(state & TAPS).
- Shift: next = {state[WIDTH-2:0], fb}.
- Priority per clock edge: seed_load > lockup recovery > enable > hold.
- seed_load=1:
  - state <= (seed_in==0) ? SEED : seed_in.
  - Counter <= 0, out_valid <= 0, rnd unchanged.
  - No shift occurs that cycle, regardless of enable.
- Lockup recovery: if state==0 (unreachable except via fault), state <= SEED and counter <= 0 on the next edge.
- enable=1 and no seed_load: state <= next and the counter increments.
- On the edge performing shift number SHIFTS (counter==SHIFTS-1):
  - Counter wraps to 0; the word is complete and equals next.
  - If out_valid==0, or out_valid==1 with out_ready==1 that cycle: rnd <= next, out_valid <= 1.
  - Otherwise the word is dropped; rnd and out_valid are held.
- enable=0: state and counter hold; the output handshake still operates.
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - Without a simultaneous new word, out_valid <= 0 on that edge.
  - With a simultaneous new word, out_valid stays 1 and rnd updates (back-to-back, no bubble).
  - rnd is stable while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 is ignored.
- Latency: first word valid after exactly SHIFTS enabled edges from reset or seed_load; output is registered.
- Counter width: $clog2(SHIFTS+1) bits, wraps only at SHIFTS.
- SHIFTS=1: a new word is produced on every enabled edge.
- Reset mid-word discards the partial count and any buffered word.

Optional Feature:
- Macro: LFSR_RNG_DROP_CNT_EN.
- When defined:
  - Adds output drop_count (16 bits).
  - Increments on every dropped word, saturates at 16'hFFFF.
  - Cleared by reset and by seed_load.
- When undefined: no drop_count port, no counter logic; drop behaviour is otherwise identical.

Test Plan:
- Default parameters, reset, enable=1, out_ready=0: state after edges 1..3 = 0x001F, 0x003F, 0x007F; after edge 9 state=0x1FFF; after edge 13 out_valid=1, rnd=0x1FF4.
- Continue holding out_ready=0 for 13 more edges: rnd stays 0x1FF4, out_valid stays 1, drop_count=1 (feature on). Raise out_ready for one cycle: out_valid falls next edge.
- out_ready tied 1 with enable=1: exactly one out_valid pulse every 13 cycles; no drops; a transfer on the same edge as a new word keeps out_valid high with the new rnd.
- seed_load with seed_in=0 mid-word (counter=7, out_valid=1): state=0x000F, counter=0, out_valid=0; next word after 13 more enabled edges equals 0x1FF4.
- seed_load with seed_in=0x1ABC and enable=1 simultaneously: state=0x1ABC, no shift that cycle; enable=0 for 5 cycles: state and counter frozen.
- Assert reset asynchronously mid-word with out_valid=1: outputs immediately rnd=0, out_valid=0, state=0x000F. Also WIDTH=4, TAPS=4'h9, SEED=1: the state sequence has period 15 and never reaches 0.
